// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - Shared constants and helpers for the polynomial add/sub pipeline
package poly_pkg;

  localparam int LANES  = 2;
  localparam int COEF_W = 25;
  localparam int Q      = 16515073;
  localparam int N      = 256;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // Width of a beat counter; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/poly_addsub_pipe_if.sv
// rtl/poly_addsub_pipe_if.sv - Input/output beat handshake bundle for poly_addsub_pipe
interface poly_addsub_pipe_if #(
  parameter int LANES  = poly_pkg::LANES,
  parameter int COEF_W = poly_pkg::COEF_W
);

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_mode;
  logic [LANES*COEF_W-1:0]   din_a;
  logic [LANES*COEF_W-1:0]   din_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*COEF_W-1:0]   dout;
  logic                      out_last;

  modport slave (
    input  in_valid, in_mode, din_a, din_b, out_ready,
    output in_ready, out_valid, dout, out_last
  );

  modport master (
    output in_valid, in_mode, din_a, din_b, out_ready,
    input  in_ready, out_valid, dout, out_last
  );

endinterface

// File: rtl/mod_addsub_lane.sv
// rtl/mod_addsub_lane.sv - One coefficient lane: raw add/sub then modular correction
module mod_addsub_lane #(
  parameter int COEF_W = poly_pkg::COEF_W,
  parameter int Q      = poly_pkg::Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_s1_en,
  input  logic              i_s2_en,
  input  logic              i_s1_mode,
  input  logic              i_s2_mode,
  input  logic [COEF_W-1:0] i_a,
  input  logic [COEF_W-1:0] i_b,
  output logic [COEF_W-1:0] o_result
);
  import poly_pkg::*;

  localparam logic [COEF_W:0] Q_X = (COEF_W+1)'(Q);

  logic [COEF_W:0]   r_raw;
  logic [COEF_W:0]   w_raw;
  logic [COEF_W-1:0] w_fix;
  logic [COEF_W-1:0] r_result;

  always_comb begin
    w_raw = {1'b0, i_a} - {1'b0, i_b};
    if (i_s1_mode == MODE_ADD) w_raw = {1'b0, i_a} + {1'b0, i_b};
  end

  // The extra top bit is the carry in add mode and the sign in sub mode.
  always_comb begin
    w_fix = r_raw[COEF_W-1:0];
    if (i_s2_mode == MODE_ADD) begin
      if (r_raw >= Q_X) w_fix = COEF_W'(r_raw - Q_X);
    end else if (r_raw[COEF_W]) begin
      w_fix = COEF_W'(r_raw + Q_X);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_raw    <= '0;
      r_result <= '0;
    end else begin
      if (i_s1_en) r_raw    <= w_raw;
      if (i_s2_en) r_result <= w_fix;
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/poly_addsub_pipe.sv
// rtl/poly_addsub_pipe.sv - Multi-lane modular add/sub pipeline with framing and range check
module poly_addsub_pipe #(
  parameter int LANES  = poly_pkg::LANES,
  parameter int COEF_W = poly_pkg::COEF_W,
  parameter int Q      = poly_pkg::Q,
  parameter int N      = poly_pkg::N
) (
  input  logic              clk,
  input  logic              rst,
  poly_addsub_pipe_if.slave bus,
  output logic              err,
  input  logic              err_clr
);
  import poly_pkg::*;

  localparam int                BEATS     = N / LANES;
  localparam int                CNT_W     = clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [COEF_W-1:0] Q_W       = COEF_W'(Q);

  logic                    r_s1_valid;
  logic                    r_s2_valid;
  logic                    r_mode;
  logic                    r_s1_mode;
  logic                    r_err;
  logic [CNT_W-1:0]        r_in_cnt;
  logic [CNT_W-1:0]        r_out_cnt;
  logic                    w_s1_load;
  logic                    w_s2_load;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_beat_mode;
  logic                    w_range_err;
  logic [LANES*COEF_W-1:0] w_dout;

  // in_ready looks through a draining S2, so a stalled pipe restarts with no bubble.
  assign w_s2_load  = !r_s2_valid || bus.out_ready;
  assign w_s1_load  = w_s2_load || !r_s1_valid;
  assign w_in_fire  = bus.in_valid && w_s1_load;
  assign w_out_fire = r_s2_valid && bus.out_ready;

  // Mode is taken live on beat 0 and held for the rest of the polynomial.
  assign w_beat_mode = (r_in_cnt == '0) ? bus.in_mode : r_mode;

  always_comb begin
    w_range_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if ((bus.din_a[i*COEF_W +: COEF_W] >= Q_W) || (bus.din_b[i*COEF_W +: COEF_W] >= Q_W))
        w_range_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_mode     <= MODE_SUB;
      r_s1_mode  <= MODE_SUB;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_s1_load) r_s1_valid <= w_in_fire;
      if (w_s2_load) r_s2_valid <= r_s1_valid;
      if (w_in_fire) begin
        r_mode    <= w_beat_mode;
        r_s1_mode <= w_beat_mode;
        r_in_cnt  <= (r_in_cnt == LAST_BEAT) ? '0 : r_in_cnt + 1'b1;
      end
      if (w_out_fire) r_out_cnt <= (r_out_cnt == LAST_BEAT) ? '0 : r_out_cnt + 1'b1;
      if (w_in_fire && w_range_err) r_err <= 1'b1;
      else if (err_clr)             r_err <= 1'b0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mod_addsub_lane #(
      .COEF_W (COEF_W),
      .Q      (Q)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_s1_en   (w_in_fire),
      .i_s2_en   (w_s2_load && r_s1_valid),
      .i_s1_mode (w_beat_mode),
      .i_s2_mode (r_s1_mode),
      .i_a       (bus.din_a[g*COEF_W +: COEF_W]),
      .i_b       (bus.din_b[g*COEF_W +: COEF_W]),
      .o_result  (w_dout[g*COEF_W +: COEF_W])
    );
  end

  assign bus.in_ready  = w_s1_load;
  assign bus.out_valid = r_s2_valid;
  assign bus.dout      = w_dout;
  assign bus.out_last  = r_s2_valid && (r_out_cnt == LAST_BEAT);
  assign err           = r_err;

endmodule

// File: tb/tb_poly_addsub_pipe.sv
// tb/tb_poly_addsub_pipe.sv - Self-checking bench for poly_addsub_pipe against a queue model
module tb_poly_addsub_pipe;

  localparam int L     = 2;
  localparam int W     = 25;
  localparam int QV    = 16515073;
  localparam int NV    = 256;
  localparam int BEATS = NV / L;

  typedef logic [L*W-1:0] vec_t;
  typedef struct {
    vec_t d;
    logic last;
    logic dchk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  logic err_clr = 1'b0;

  poly_addsub_pipe_if #(.LANES(L), .COEF_W(W)) bus ();

  poly_addsub_pipe #(.LANES(L), .COEF_W(W), .Q(QV), .N(NV)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err     (err),
    .err_clr (err_clr)
  );

  int   errors = 0;
  int   checks = 0;
  int   stall_cycles = 0;
  int   rdy_mode = 0;
  exp_t q[$];
  int   m_cnt = 0;
  logic m_mode = 1'b0;
  logic exp_err = 1'b0;
  logic stalled = 1'b0;
  logic prev_last = 1'b0;
  vec_t prev_d = '0;

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_op(input logic add, input longint a, input longint b);
    longint r;
    if (add) r = (a + b) % QV;
    else     r = (a - b + QV) % QV;
    return W'(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < L; i++) begin
      int r;
      logic [W-1:0] c;
      r = int'($urandom_range(9, 0));
      if (r == 0)      c = '0;
      else if (r == 1) c = W'(QV - 1);
      else             c = W'($urandom_range(QV - 1, 0));
      v[i*W +: W] = c;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic mode, input vec_t a, input vec_t b);
    int   waits;
    logic ok;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.din_a    = a;
    bus.din_b    = b;
    forever begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
      if (waits > 2000) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: in_ready low for %0d cycles", waits);
        break;
      end
    end
    stall_cycles += waits;
    bus.in_valid = 1'b0;
  endtask

  task automatic rand_beats(input int n, input int idle_pct);
    for (int k = 0; k < n; k++) begin
      if (int'($urandom_range(99, 0)) < idle_pct) step();
      push(1'($urandom_range(1, 0)), rand_vec(), rand_vec());
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_mode = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 2000) begin
      step();
      n++;
    end
    chk("drain_queue", q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0)      bus.out_ready = 1'b1;
    else if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(1, 0));
    else                    bus.out_ready = 1'b0;
  end

  always @(negedge clk) begin : mon
    exp_t         e;
    vec_t         ed;
    logic [W-1:0] al, bl;
    logic         bad;
    logic         mode;
    if (!rst) begin
      q.delete();
      m_cnt   = 0;
      m_mode  = 1'b0;
      exp_err = 1'b0;
      stalled = 1'b0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_err", err, 0);
    end else begin
      chk("err", err, exp_err);
      if (stalled) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_dout", bus.dout, prev_d);
        chk("hold_last", bus.out_last, prev_last);
      end
      if (!bus.out_valid) begin
        chk("last_without_valid", bus.out_last, 0);
      end else if (bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          if (e.dchk) chk("dout", bus.dout, e.d);
          chk("out_last", bus.out_last, e.last);
        end
      end
      stalled   = bus.out_valid && !bus.out_ready;
      prev_d    = bus.dout;
      prev_last = bus.out_last;
      if (bus.in_valid && bus.in_ready) begin
        mode   = (m_cnt == 0) ? bus.in_mode : m_mode;
        m_mode = mode;
        bad    = 1'b0;
        for (int i = 0; i < L; i++) begin
          al = bus.din_a[i*W +: W];
          bl = bus.din_b[i*W +: W];
          if (al >= QV || bl >= QV) bad = 1'b1;
          ed[i*W +: W] = ref_op(mode, al, bl);
        end
        e.d    = ed;
        e.last = (m_cnt == BEATS - 1);
        e.dchk = !bad;
        q.push_back(e);
        m_cnt = (m_cnt + 1) % BEATS;
        if (bad)          exp_err = 1'b1;
        else if (err_clr) exp_err = 1'b0;
      end else if (err_clr) begin
        exp_err = 1'b0;
      end
    end
  end

  initial begin
    int   sc;
    vec_t bad_b;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.din_a     = '0;
    bus.din_b     = '0;
    bus.out_ready = 1'b1;

    chk("model_sub_0_1", ref_op(1'b0, 0, 1), 16515072);
    chk("model_sub_5_5", ref_op(1'b0, 5, 5), 0);
    chk("model_add_wrap", ref_op(1'b1, 16515072, 1), 0);
    chk("model_add_max", ref_op(1'b1, 16515072, 16515072), 16515071);
    chk("model_add_small", ref_op(1'b1, 3, 4), 7);

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Polynomial 0: sub, latency, full-rate stream, mode toggled at beat 10.
    push(1'b0, {25'd5, 25'd0}, {25'd5, 25'd1});
    @(negedge clk);
    chk("lat_cycle1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", bus.out_valid, 1);
    chk("sub_literal", bus.dout, {25'd0, 25'd16515072});
    step();
    sc = stall_cycles;
    for (int k = 1; k < BEATS; k++) push(k >= 10, rand_vec(), rand_vec());
    chk("stream_no_stall", stall_cycles - sc, 0);

    // Polynomial 1: add literals, then random backpressure.
    push(1'b1, {25'd16515072, 25'd16515072}, {25'd16515072, 25'd1});
    @(negedge clk);
    @(negedge clk);
    chk("add_literal", bus.dout, {25'd16515071, 25'd0});
    step();
    push(1'b0, {25'd9, 25'd3}, {25'd1, 25'd4});
    @(negedge clk);
    @(negedge clk);
    chk("add_latched_literal", bus.dout, {25'd10, 25'd7});
    step();
    rdy_mode = 1;
    rand_beats(BEATS - 2, 25);
    rand_beats(BEATS, 25);
    rand_beats(BEATS, 25);
    drain();

    // Range check and sticky error.
    chk("err_clean", err, 0);
    bad_b = {25'(QV), 25'd7};
    push(1'b0, rand_vec(), bad_b);
    @(negedge clk);
    chk("err_set", err, 1);
    step();
    err_clr = 1'b1;
    push(1'b0, {25'd1, 25'h1FFFFFF}, {25'd0, 25'd0});
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr_vs_new", err, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 0);
    step();

    // Full-pipe stall, then restart with simultaneous accept and emit.
    rdy_mode = 2;
    step();
    step();
    push(1'b0, rand_vec(), rand_vec());
    push(1'b0, rand_vec(), rand_vec());
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    step();
    sc = stall_cycles;
    push(1'b0, rand_vec(), rand_vec());
    chk("accept_emit_same_cycle", stall_cycles - sc, 0);

    // Reset mid-polynomial, then a fresh add polynomial from beat 0.
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_dout", bus.dout, 0);
    step();
    rst = 1'b1;
    push(1'b1, {25'd1, 25'd3}, {25'd2, 25'd4});
    @(negedge clk);
    @(negedge clk);
    chk("restart_beat0_add", bus.dout, {25'd3, 25'd7});
    step();
    rdy_mode = 1;
    rand_beats(BEATS - 1, 20);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
